// File: rtl/i2c_clocked_target_pkg.sv
// Shared I2C target definitions: FSM state encoding, R/W and ACK bit values, general-call address.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package i2c_clocked_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_e;

    localparam logic       I2C_RW_WRITE   = 1'b0;
    localparam logic       I2C_RW_READ    = 1'b1;
    localparam logic [6:0] I2C_GCALL_ADDR = 7'h00;
    localparam logic       I2C_ACK        = 1'b0;
    localparam logic       I2C_NACK       = 1'b1;

    // True when an address byte ({addr[6:0], rw}) selects this target.
    // A general call is only accepted as a write.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] own_addr,
                                        input logic       gcall_en);
        return (addr_byte[7:1] == own_addr) ||
               (gcall_en && (addr_byte[7:1] == I2C_GCALL_ADDR) && (addr_byte[0] == I2C_RW_WRITE));
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus glitch filter for one open-drain bus line; filtered level idles at 1.
// Latency: 2 + FILTER_LEN clocks from raw_i to filt_o.
// Backpressure: none; free-running sampler.
// Ports: clock, reset_n (async active-low), raw_i (asynchronous bus level), filt_o (filtered level).
module i2c_line_filter #(
    parameter int FILTER_LEN = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_i,
    output logic filt_o
);

    localparam logic [2:0] LAST = 3'(FILTER_LEN - 1);

    logic [1:0] sync_q;
    logic       filt_q;
    logic [2:0] cnt_q;

    // cnt_q counts consecutive synchronised samples that disagree with filt_q;
    // the level flips on the FILTER_LEN-th such sample, any agreeing sample restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= 3'd0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (sync_q[1] == filt_q) begin
                cnt_q <= 3'd0;
            end else if (cnt_q == LAST) begin
                filt_q <= sync_q[1];
                cnt_q  <= 3'd0;
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/i2c_clocked_target.sv
// I2C target oversampled on the system clock: 7-bit address match, one data register written/read over I2C.
// Latency: bus events seen 2+FILTER_LEN clocks after the pins move; sda_oe changes one clock after a filtered SCL fall.
// Backpressure: none; never stretches SCL, relies on bus phases >= FILTER_LEN+4 clocks.
// Ports: clock, reset_n (async active-low), scl_in/sda_in (raw bus), sda_oe (1 = pull SDA low),
//   address (own 7-bit address), data_out (data register), rx_valid (write byte stored), busy (addressed).
// Build option: define I2C_TARGET_GCALL_EN to also accept general-call writes to address 7'h00.
module i2c_clocked_target
    import i2c_clocked_target_pkg::*;
#(
    parameter int         FILTER_LEN = 2,
    parameter logic [7:0] RESET_DATA = 8'h00
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] address,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       busy
);

`ifdef I2C_TARGET_GCALL_EN
    localparam logic GCALL_EN = 1'b1;
`else
    localparam logic GCALL_EN = 1'b0;
`endif

    logic scl_f, sda_f;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clock  (clock),
        .reset_n(reset_n),
        .raw_i  (scl_in),
        .filt_o (scl_f)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clock  (clock),
        .reset_n(reset_n),
        .raw_i  (sda_in),
        .filt_o (sda_f)
    );

    state_e     state_q;
    logic       scl_prev_q, sda_prev_q;
    logic [2:0] cnt_q;
    logic [6:0] rx_q;
    logic [6:0] tx_q;       // bits still to be sent, next one at [6]
    logic [7:0] data_out_q;
    logic       sda_oe_q, rx_valid_q, busy_q;
    logic       rw_q;
    logic       phase_q;    // ACK states: first SCL fall seen / RD_ACK: master acknowledged

    logic       start_evt, stop_evt, scl_rise, scl_fall;
    logic [7:0] rx_d;

    assign start_evt = scl_f && scl_prev_q && sda_prev_q && !sda_f;
    assign stop_evt  = scl_f && scl_prev_q && !sda_prev_q && sda_f;
    assign scl_rise  = scl_f && !scl_prev_q;
    assign scl_fall  = !scl_f && scl_prev_q;
    assign rx_d      = {rx_q, sda_f};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            cnt_q      <= 3'd0;
            rx_q       <= 7'd0;
            tx_q       <= 7'd0;
            data_out_q <= RESET_DATA;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            rx_valid_q <= 1'b0;
            // START/STOP outrank any SCL edge seen in the same clock.
            if (start_evt) begin
                state_q  <= ST_ADDR;
                cnt_q    <= 3'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                phase_q  <= 1'b0;
            end else if (stop_evt) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: if (scl_rise) begin
                        rx_q <= rx_d[6:0];
                        if (cnt_q == 3'd7) begin
                            cnt_q <= 3'd0;
                            if (addr_match(rx_d, address, GCALL_EN)) begin
                                busy_q  <= 1'b1;
                                rw_q    <= rx_d[0];
                                phase_q <= 1'b0;
                                state_q <= ST_ADDR_ACK;
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    // Drive ACK on the fall after the 8th bit, release on the fall ending the ACK.
                    ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_q <= 1'b1;
                            phase_q  <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            cnt_q   <= 3'd0;
                            if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
                                state_q  <= ST_RD_DATA;
                                tx_q     <= data_out_q[6:0];
                                sda_oe_q <= !data_out_q[7];
                            end else begin
                                state_q  <= ST_WR_DATA;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    ST_WR_DATA: if (scl_rise) begin
                        rx_q <= rx_d[6:0];
                        if (cnt_q == 3'd7) begin
                            data_out_q <= rx_d;
                            rx_valid_q <= 1'b1;
                            cnt_q      <= 3'd0;
                            phase_q    <= 1'b0;
                            state_q    <= ST_WR_ACK;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    // Bit 7 went out on entry; the 8th fall here ends bit 0 and frees SDA for the master.
                    ST_RD_DATA: if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_oe_q <= 1'b0;
                            cnt_q    <= 3'd0;
                            phase_q  <= 1'b0;
                            state_q  <= ST_RD_ACK;
                        end else begin
                            sda_oe_q <= !tx_q[6];
                            tx_q     <= {tx_q[5:0], 1'b0};
                            cnt_q    <= cnt_q + 3'd1;
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_f == I2C_NACK) begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IGNORE;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            phase_q  <= 1'b0;
                            cnt_q    <= 3'd0;
                            tx_q     <= data_out_q[6:0];
                            sda_oe_q <= !data_out_q[7];
                            state_q  <= ST_RD_DATA;
                        end
                    end
                    default: sda_oe_q <= 1'b0;  // IDLE, IGNORE
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign data_out = data_out_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_clocked_target.sv
// Bench for i2c_clocked_target: a task-based I2C master on a wired-AND SDA, checked against a
// transaction-level model (stored byte, count of stored bytes, expected ACK per address byte).
// Latency/backpressure: n/a.
module tb_i2c_clocked_target;

    localparam logic [6:0] OWN  = 7'd84;
    localparam logic [7:0] RSTD = 8'h00;
`ifdef I2C_TARGET_GCALL_EN
    localparam logic GCALL_EN = 1'b1;
`else
    localparam logic GCALL_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       m_scl, m_sda;
    logic       sda_bus;
    logic       sda_oe, rx_valid, busy;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int oe_cnt = 0;

    logic [7:0] exp_data = RSTD;
    int         exp_rx   = 0;

    always #5 clock = ~clock;

    // Open-drain bus: either side pulling low wins.
    assign sda_bus = m_sda & ~sda_oe;

    i2c_clocked_target #(.FILTER_LEN(2), .RESET_DATA(RSTD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .scl_in  (m_scl),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .address (OWN),
        .data_out(data_out),
        .rx_valid(rx_valid),
        .busy    (busy)
    );

    always @(posedge clock) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (sda_oe)   oe_cnt <= oe_cnt + 1;
    end

    function automatic logic hit(input logic [7:0] a);
        return (a[7:1] == OWN) || (GCALL_EN && a == 8'h00);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One SCL period of 24 clocks: data changes mid-low, sampled mid-high.
    task automatic bit_xfer(input logic b, output logic s);
        clk_n(6); m_sda = b;
        clk_n(6); m_scl = 1'b1;
        clk_n(6); s = sda_bus;
        clk_n(6); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; clk_n(6);
        m_scl = 1'b1; clk_n(12);
        m_sda = 1'b0; clk_n(12);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        clk_n(6);  m_sda = 1'b0;
        clk_n(6);  m_scl = 1'b1;
        clk_n(12); m_sda = 1'b1;
        clk_n(12);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ackb, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(ackb, s);
    endtask

    task automatic write_txn(input logic [7:0] a, input logic [7:0] d);
        logic ack;
        logic h;
        h = hit(a);
        i2c_start();
        send_byte(a, ack);
        check("wr_addr_ack", 32'(ack), 32'(!h));
        check("wr_busy", 32'(busy), 32'(h));
        send_byte(d, ack);
        check("wr_data_ack", 32'(ack), 32'(!h));
        i2c_stop();
        if (h) begin
            exp_data = d;
            exp_rx++;
        end
        check("wr_data_out", 32'(data_out), 32'(exp_data));
        check("wr_rx_count", 32'(rx_cnt), 32'(exp_rx));
        check("wr_busy_end", 32'(busy), 32'd0);
    endtask

    task automatic read_txn();
        logic       ack;
        logic [7:0] d;
        i2c_start();
        send_byte({OWN, 1'b1}, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b1, d);
        check("rd_byte", 32'(d), 32'(exp_data));
        clk_n(8);
        check("rd_nack_busy", 32'(busy), 32'd0);
        check("rd_nack_oe", 32'(sda_oe), 32'd0);
        i2c_stop();
        check("rd_rx_count", 32'(rx_cnt), 32'(exp_rx));
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         snap_oe, snap_rx, n;
        logic [6:0] ra;

        reset_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        clk_n(3);
        check("rst_oe", 32'(sda_oe), 32'd0);
        check("rst_data", 32'(data_out), 32'(RSTD));
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        clk_n(10);

        // Plain write, then read it back with NACK.
        write_txn({OWN, 1'b0}, 8'h3C);
        read_txn();

        // Another address: ignored entirely.
        snap_oe = oe_cnt;
        write_txn({7'd81, 1'b0}, 8'h55);
        check("miss_oe_never", 32'(oe_cnt - snap_oe), 32'd0);

        // Multi-byte write, repeated START, read with ACK then NACK.
        i2c_start();
        send_byte({OWN, 1'b0}, ack); check("mb_addr_ack", 32'(ack), 32'd0);
        send_byte(8'h11, ack);       check("mb_d0_ack", 32'(ack), 32'd0);
        send_byte(8'h22, ack);       check("mb_d1_ack", 32'(ack), 32'd0);
        exp_data = 8'h22; exp_rx += 2;
        clk_n(4);
        check("mb_rx_count", 32'(rx_cnt), 32'(exp_rx));
        check("mb_data_out", 32'(data_out), 32'(exp_data));
        i2c_start();
        send_byte({OWN, 1'b1}, ack); check("sr_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, d);          check("sr_rd0", 32'(d), 32'(exp_data));
        read_byte(1'b1, d);          check("sr_rd1", 32'(d), 32'(exp_data));
        clk_n(8);
        check("sr_busy_nack", 32'(busy), 32'd0);
        i2c_stop();
        check("sr_rx_count", 32'(rx_cnt), 32'(exp_rx));

        // Reset while the target drives a read bit.
        i2c_start();
        send_byte({OWN, 1'b1}, ack); check("rr_addr_ack", 32'(ack), 32'd0);
        n = 0;
        while (!sda_oe && n < 40) begin
            clk_n(1);
            n++;
        end
        check("rr_oe_driving", 32'(sda_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rr_oe_async", 32'(sda_oe), 32'd0);
        check("rr_data_reset", 32'(data_out), 32'(RSTD));
        check("rr_busy_reset", 32'(busy), 32'd0);
        exp_data = RSTD;
        clk_n(3);
        reset_n = 1'b1;
        m_sda = 1'b1;
        clk_n(6);
        i2c_stop();
        write_txn({OWN, 1'b0}, 8'h7E);

        // One-clock SDA glitch while SCL high: no START, so a following address is not ACKed.
        snap_oe = oe_cnt;
        snap_rx = rx_cnt;
        m_sda = 1'b0; clk_n(1); m_sda = 1'b1;
        clk_n(10);
        check("gl_busy", 32'(busy), 32'd0);
        m_scl = 1'b0;
        send_byte({OWN, 1'b0}, ack);
        check("gl_no_ack", 32'(ack), 32'd1);
        check("gl_oe_never", 32'(oe_cnt - snap_oe), 32'd0);
        i2c_stop();
        check("gl_rx_none", 32'(rx_cnt - snap_rx), 32'd0);
        check("gl_data", 32'(data_out), 32'(exp_data));

        // General call write: accepted only in the build that enables it.
        write_txn(8'h00, 8'h99);

        // Randomised writes to own or foreign addresses, with periodic read-back.
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) ra = OWN;
            else ra = 7'($urandom_range(1, 127));
            write_txn({ra, 1'b0}, 8'($urandom_range(0, 255)));
            if (k % 2 == 1) read_txn();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
